// File: rtl/findmax_driver.sv
// Purpose : stimulus source for the findmax unit; buffers N samples, pulses the
//           findmax reset, streams the samples on o_x, captures max/argmax.
// Latency : RST_CYCLES reset + N stream cycles + WAIT until i_finish, +1 capture.
// Backpressure: none; i_start/i_wr_en are dropped while busy, no queuing.
//
// Ports:
//   i_clk, i_rst            clock (posedge) and synchronous active-high reset
//   i_wr_en/addr/data       sample buffer write port (IDLE only)
//   i_start                 begin a run (sampled in IDLE only)
//   o_busy                  high in every state except IDLE
//   o_dut_rst, o_x          reset and registered sample stream to findmax
//   i_max/i_argmax/i_finish result interface from findmax
//   o_result_max/argmax     captured result; o_done pulses when they update
//   o_timeout               sticky, set when finish never arrives; cleared by start
//   o_mismatch              (FINDMAX_DRIVER_CHECK_EN only) findmax result differs
//                           from the locally computed max/argmax
//
// Optional feature macro: FINDMAX_DRIVER_CHECK_EN

module findmax_driver #(
  parameter int W          = 8,
  parameter int AW         = 3,
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 1000
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [W-1:0]  i_wr_data,
  input  logic          i_start,
  output logic          o_busy,
  output logic          o_dut_rst,
  output logic [W-1:0]  o_x,
  input  logic [W-1:0]  i_max,
  input  logic [AW-1:0] i_argmax,
  input  logic          i_finish,
  output logic [W-1:0]  o_result_max,
  output logic [AW-1:0] o_result_argmax,
  output logic          o_done,
  output logic          o_timeout
`ifdef FINDMAX_DRIVER_CHECK_EN
  ,
  output logic          o_mismatch
`endif
);

  localparam int N      = 1 << AW;
  localparam int CNT_MX = (TIMEOUT > RST_CYCLES) ? TIMEOUT : RST_CYCLES;
  localparam int CW     = $clog2(CNT_MX) + 1;

  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
  localparam logic [AW-1:0] K_LAST   = AW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RSTP,
    S_STRM,
    S_WAIT,
    S_CAPT
  } state_t;

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic [AW-1:0]  r_k;
  logic [W-1:0]   r_buf [N];

  logic           w_wr;
  logic [W-1:0]   w_buf0;
  logic [AW-1:0]  w_k_nxt;
  logic [W-1:0]   w_buf_nxt;

`ifdef FINDMAX_DRIVER_CHECK_EN
  logic [W-1:0]   r_chk_max;
  logic [AW-1:0]  r_chk_arg;
`endif

  assign w_wr      = (r_state == S_IDLE) && i_wr_en && !i_rst;
  // A write to entry 0 in the same cycle as start must reach the first sample.
  assign w_buf0    = (w_wr && (i_wr_addr == '0)) ? i_wr_data : r_buf[0];
  assign w_k_nxt   = r_k + 1'b1;
  assign w_buf_nxt = r_buf[w_k_nxt];

  // Sample buffer: no reset, contents survive RST.
  always_ff @(posedge i_clk) begin
    if (w_wr) begin
      r_buf[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state         <= S_IDLE;
      r_cnt           <= '0;
      r_k             <= '0;
      o_busy          <= 1'b0;
      o_dut_rst       <= 1'b0;
      o_x             <= '0;
      o_result_max    <= '0;
      o_result_argmax <= '0;
      o_done          <= 1'b0;
      o_timeout       <= 1'b0;
`ifdef FINDMAX_DRIVER_CHECK_EN
      o_mismatch      <= 1'b0;
      r_chk_max       <= '0;
      r_chk_arg       <= '0;
`endif
    end else begin
      o_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state   <= S_RSTP;
            r_cnt     <= '0;
            o_busy    <= 1'b1;
            o_dut_rst <= 1'b1;
            o_x       <= w_buf0;
            o_timeout <= 1'b0;
`ifdef FINDMAX_DRIVER_CHECK_EN
            o_mismatch <= 1'b0;
`endif
          end
        end

        // o_x already holds buffer[0] for the whole reset pulse.
        S_RSTP: begin
          if (r_cnt == RST_LAST) begin
            r_state   <= S_STRM;
            r_cnt     <= '0;
            r_k       <= '0;
            o_dut_rst <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        // o_x carries buffer[r_k] during stream cycle r_k.
        S_STRM: begin
`ifdef FINDMAX_DRIVER_CHECK_EN
          // Strict greater-than keeps the lowest index on ties.
          if ((r_k == '0) || (o_x > r_chk_max)) begin
            r_chk_max <= o_x;
            r_chk_arg <= r_k;
          end
`endif
          if (r_k == K_LAST) begin
            r_state <= S_WAIT;
            r_cnt   <= '0;
          end else begin
            r_k <= w_k_nxt;
            o_x <= w_buf_nxt;
          end
        end

        // Result is captured on the edge that first sees finish, so the
        // CAPT cycle shows the new result together with o_done.
        S_WAIT: begin
          if (i_finish) begin
            r_state         <= S_CAPT;
            o_result_max    <= i_max;
            o_result_argmax <= i_argmax;
            o_done          <= 1'b1;
`ifdef FINDMAX_DRIVER_CHECK_EN
            o_mismatch <= (i_max != r_chk_max) || (i_argmax != r_chk_arg);
`endif
          end else if (r_cnt == TO_LAST) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            o_busy    <= 1'b0;
            o_timeout <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_CAPT: begin
          r_state <= S_IDLE;
          o_busy  <= 1'b0;
        end

        default: begin
          r_state   <= S_IDLE;
          o_busy    <= 1'b0;
          o_dut_rst <= 1'b0;
        end
      endcase
    end
  end

endmodule
